mem_bus_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single RAM port among NUM_REQ masters (DMA channels, CPU

---
 rtl/mem_bus_arbiter_if.sv | 33 +++
 rtl/mem_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Shared-RAM arbitration bus: per-master request/strobe bundles in, granted RAM port out.
// The arbiter connects through the slave modport; requesting masters (or a bench) use master.
interface mem_bus_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 32,
    parameter int DW      = 32
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_wr_en;
    logic [NUM_REQ-1:0]    req_rd_en;
    logic [NUM_REQ-1:0]    gnt;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic                  mem_wr_enable;
    logic                  mem_rd_enable;
    logic [IDW-1:0]        owner_id;
    logic                  busy;
    logic                  proto_err;

    modport master (
        output req, req_addr, req_wdata, req_wr_en, req_rd_en,
        input  gnt, mem_addr, mem_wdata, mem_wr_enable, mem_rd_enable, owner_id, busy, proto_err
    );

    modport slave (
        input  req, req_addr, req_wdata, req_wr_en, req_rd_en,
        output gnt, mem_addr, mem_wdata, mem_wr_enable, mem_rd_enable, owner_id, busy, proto_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of the single RAM port with a per-grant hold quota and a one-cycle
// turnaround gap between owners; the owner's strobes are muxed from the registered owner index.
module mem_bus_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    mem_bus_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int HCW = (MAX_HOLD > 32'sd1) ? $clog2(MAX_HOLD + 32'sd1) : 32'sd1;
    localparam logic [HCW-1:0] HOLD_SAT  = (MAX_HOLD > 32'sd0) ? HCW'(MAX_HOLD) : {HCW{1'b1}};
    localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 32'sd0) ? HCW'(MAX_HOLD - 32'sd1) : {HCW{1'b1}};
    localparam logic [IDW-1:0] LAST_INIT = IDW'(NUM_REQ - 32'sd1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWNED   = 2'd1,
        ST_HANDOFF = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [NUM_REQ-1:0] gnt_r, gnt_nxt_s;
    logic [IDW-1:0]     owner_r, owner_nxt_s;
    logic [IDW-1:0]     last_r, last_nxt_s;
    logic [HCW-1:0]     hold_r, hold_nxt_s;
    logic               proto_err_r;
    logic [IDW:0]       pick_s;
    logic               owned_s, live_s, owner_req_s, others_s, quota_hit_s, conflict_s;
    logic [AW-1:0]      addr_arr_s  [NUM_REQ];
    logic [DW-1:0]      wdata_arr_s [NUM_REQ];

    // Returns {found, index}; scanning from the far end lets the nearest requester after 'last' win.
    function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [IDW-1:0] last);
        logic [IDW:0]   res;
        logic [IDW-1:0] sel;
        res = {(IDW+1){1'b0}};
        for (int i = NUM_REQ; i >= 32'sd1; i--) begin
            sel = IDW'((int'(last) + i) % NUM_REQ);
            if (r[sel]) begin
                res = {1'b1, sel};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Unpack the per-master address/data buses so the owner can be selected by index.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr_s[i]  = bus.req_addr[i*AW +: AW];
            wdata_arr_s[i] = bus.req_wdata[i*DW +: DW];
        end
    end

    // Owner status and RAM-port mux; a dropped request silences the strobes in that same cycle.
    always_comb begin
        owned_s     = (state_r == ST_OWNED);
        owner_req_s = bus.req[owner_r];
        live_s      = owned_s & owner_req_s;
        others_s    = |(bus.req & ~gnt_r);
        quota_hit_s = (MAX_HOLD > 32'sd0) && (hold_r == HOLD_LAST);
        conflict_s  = live_s & bus.req_wr_en[owner_r] & bus.req_rd_en[owner_r];
        bus.mem_wr_enable = live_s & bus.req_wr_en[owner_r];
        bus.mem_rd_enable = live_s & bus.req_rd_en[owner_r] & ~bus.req_wr_en[owner_r];
        if (owned_s) begin
            bus.mem_addr  = addr_arr_s[owner_r];
            bus.mem_wdata = wdata_arr_s[owner_r];
        end else begin
            bus.mem_addr  = {AW{1'b0}};
            bus.mem_wdata = {DW{1'b0}};
        end
    end

    // Next-state logic: arbitrate from IDLE/HANDOFF, release or preempt from OWNED.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        owner_nxt_s = owner_r;
        last_nxt_s  = last_r;
        hold_nxt_s  = hold_r;
        pick_s      = rr_pick(bus.req, last_r);
        case (state_r)
            ST_IDLE, ST_HANDOFF: begin
                hold_nxt_s = {HCW{1'b0}};
                if (pick_s[IDW]) begin
                    state_nxt_s = ST_OWNED;
                    gnt_nxt_s   = NUM_REQ'(1'b1) << pick_s[IDW-1:0];
                    owner_nxt_s = pick_s[IDW-1:0];
                    last_nxt_s  = pick_s[IDW-1:0];
                end else begin
                    state_nxt_s = ST_IDLE;
                    gnt_nxt_s   = {NUM_REQ{1'b0}};
                end
            end
            ST_OWNED: begin
                if (!owner_req_s || (quota_hit_s && others_s)) begin
                    state_nxt_s = ST_HANDOFF;
                    gnt_nxt_s   = {NUM_REQ{1'b0}};
                    hold_nxt_s  = {HCW{1'b0}};
                end else if (quota_hit_s) begin
                    hold_nxt_s = {HCW{1'b0}};
                end else if (hold_r != HOLD_SAT) begin
                    hold_nxt_s = hold_r + HCW'(1'b1);
                end else begin
                    hold_nxt_s = hold_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = {NUM_REQ{1'b0}};
                hold_nxt_s  = {HCW{1'b0}};
            end
        endcase
    end

    // Arbitration state registers; last owner resets to the top index so master 0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            gnt_r   <= {NUM_REQ{1'b0}};
            owner_r <= {IDW{1'b0}};
            last_r  <= LAST_INIT;
            hold_r  <= {HCW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            owner_r <= owner_nxt_s;
            last_r  <= last_nxt_s;
            hold_r  <= hold_nxt_s;
        end
    end

    // Registered one-cycle flag for each cycle the owner drove read and write together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            proto_err_r <= 1'b0;
        end else begin
            proto_err_r <= conflict_s;
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.owner_id  = owner_r;
    assign bus.busy      = owned_s;
    assign bus.proto_err = proto_err_r;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: reset, first grant, rotation/quota, renewal,
// RAM-port isolation, rd/wr conflict and asynchronous reset mid-burst.
module tb_mem_bus_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_HOLD = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) bus ();

    mem_bus_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [NUM_REQ-1:0] gnt_q   [$];
    logic [AW-1:0]      addr_q  [$];
    int                 owner_q [$];

    task automatic clear_inputs();
        bus.req       = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wr_en = '0;
        bus.req_rd_en = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        total++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.owner_id !== 2'd0 || bus.proto_err !== 1'b0) begin
            $display("FAIL reset_state: gnt=%b busy=%b owner=%0d perr=%b, want 0000 0 0 0",
                     bus.gnt, bus.busy, bus.owner_id, bus.proto_err);
            bad++;
        end
        total++;
        if (bus.mem_wr_enable !== 1'b0 || bus.mem_rd_enable !== 1'b0 || bus.mem_addr !== 32'h0) begin
            $display("FAIL reset_port: wr=%b rd=%b addr=%h, want 0 0 0",
                     bus.mem_wr_enable, bus.mem_rd_enable, bus.mem_addr);
            bad++;
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (bus.gnt !== 4'b0000) begin
            $display("FAIL idle_no_req: gnt=%b want 0000", bus.gnt);
            bad++;
        end
    endtask

    task automatic test_first_grant();
        logic [NUM_REQ-1:0] exp;
        do_reset();
        bus.req = 4'b0001;
        gnt_q.push_back(4'b0001);
        #1;
        total++;
        if (bus.gnt !== 4'b0000) begin
            $display("FAIL first_latency: gnt=%b before edge, want 0000", bus.gnt);
            bad++;
        end
        @(negedge clk);
        exp = gnt_q.pop_front();
        total++;
        if (bus.gnt !== exp || bus.busy !== 1'b1 || bus.owner_id !== 2'd0) begin
            $display("FAIL first_grant: gnt=%b busy=%b owner=%0d, want %b 1 0",
                     bus.gnt, bus.busy, bus.owner_id, exp);
            bad++;
        end
    endtask

    task automatic test_rotation();
        logic [NUM_REQ-1:0] prev, cur, exp;
        int run, gap, cyc, e;
        bit started;
        do_reset();
        for (int k = 0; k < 5; k++) owner_q.push_back(k % NUM_REQ);
        bus.req = 4'b1111;
        prev = '0; run = 0; gap = 0; cyc = 0; started = 1'b0;
        while (owner_q.size() > 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            cur = bus.gnt;
            if (cur != '0) begin
                if (prev == '0) begin
                    if (started) begin
                        total++;
                        if (gap !== 1) begin
                            $display("FAIL rot_gap: gap=%0d cycles, want 1", gap);
                            bad++;
                        end
                    end
                    started = 1'b1;
                    e = owner_q.pop_front();
                    exp = '0;
                    exp[e] = 1'b1;
                    total++;
                    if (cur !== exp || int'(bus.owner_id) !== e) begin
                        $display("FAIL rot_owner: gnt=%b owner=%0d, want %b %0d", cur, bus.owner_id, exp, e);
                        bad++;
                    end
                    run = 1;
                end else begin
                    run++;
                end
            end else begin
                if (prev != '0) begin
                    total++;
                    if (run !== MAX_HOLD) begin
                        $display("FAIL rot_hold: owned %0d cycles, want %0d", run, MAX_HOLD);
                        bad++;
                    end
                    gap = 1;
                end else begin
                    gap++;
                end
            end
            prev = cur;
        end
        total++;
        if (owner_q.size() != 0) begin
            $display("FAIL rot_timeout: %0d grants outstanding, want 0", owner_q.size());
            bad++;
            owner_q.delete();
        end
    endtask

    task automatic test_renewal();
        int drops;
        do_reset();
        bus.req = 4'b0100;
        @(negedge clk);
        total++;
        if (bus.gnt !== 4'b0100 || bus.owner_id !== 2'd2) begin
            $display("FAIL renew_start: gnt=%b owner=%0d, want 0100 2", bus.gnt, bus.owner_id);
            bad++;
        end
        drops = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.gnt !== 4'b0100 || bus.busy !== 1'b1) drops++;
        end
        total++;
        if (drops !== 0) begin
            $display("FAIL renew_gap: %0d cycles without grant, want 0", drops);
            bad++;
        end
    endtask

    task automatic test_isolation();
        logic [AW-1:0] exp;
        int leaks;
        do_reset();
        bus.req = 4'b1010;
        bus.req_wr_en = 4'b1010;
        bus.req_addr[1*AW +: AW] = 32'h100;
        bus.req_addr[3*AW +: AW] = 32'h200;
        @(negedge clk);
        total++;
        if (bus.gnt !== 4'b0010) begin
            $display("FAIL iso_grant: gnt=%b want 0010", bus.gnt);
            bad++;
        end
        leaks = 0;
        for (int k = 0; k < 6; k++) begin
            bus.req_addr[1*AW +: AW] = 32'h100 + k;
            bus.req_addr[3*AW +: AW] = 32'h200 + k;
            bus.req_wdata[1*DW +: DW] = 32'hA100 + k;
            bus.req_wdata[3*DW +: DW] = 32'hB300 + k;
            addr_q.push_back(32'h100 + k);
            #1;
            exp = addr_q.pop_front();
            if (bus.mem_addr !== exp || bus.mem_wdata !== (32'hA100 + k) ||
                bus.mem_wr_enable !== 1'b1 || bus.mem_rd_enable !== 1'b0) leaks++;
            @(negedge clk);
        end
        total++;
        if (leaks !== 0) begin
            $display("FAIL iso_mux: %0d bad cycles, last addr=%h wr=%b, want addr=%h wr=1",
                     leaks, bus.mem_addr, bus.mem_wr_enable, exp);
            bad++;
        end
        bus.req = 4'b1000;
        #1;
        total++;
        if (bus.mem_wr_enable !== 1'b0) begin
            $display("FAIL iso_drop_strobe: wr=%b in req-drop cycle, want 0", bus.mem_wr_enable);
            bad++;
        end
        @(negedge clk);
        total++;
        if (bus.gnt !== 4'b0000 || bus.mem_wr_enable !== 1'b0 || bus.mem_addr !== 32'h0) begin
            $display("FAIL iso_turnaround: gnt=%b wr=%b addr=%h, want 0000 0 0",
                     bus.gnt, bus.mem_wr_enable, bus.mem_addr);
            bad++;
        end
        @(negedge clk);
        total++;
        if (bus.gnt !== 4'b1000 || bus.mem_addr !== 32'h205 || bus.mem_wr_enable !== 1'b1) begin
            $display("FAIL iso_next_owner: gnt=%b addr=%h wr=%b, want 1000 205 1",
                     bus.gnt, bus.mem_addr, bus.mem_wr_enable);
            bad++;
        end
    endtask

    task automatic test_conflict();
        do_reset();
        bus.req = 4'b0001;
        @(negedge clk);
        bus.req_addr[0 +: AW] = 32'h40;
        bus.req_rd_en = 4'b0001;
        bus.req_wr_en = 4'b0001;
        #1;
        total++;
        if (bus.mem_wr_enable !== 1'b1 || bus.mem_rd_enable !== 1'b0 || bus.proto_err !== 1'b0) begin
            $display("FAIL conf_strobes: wr=%b rd=%b perr=%b, want 1 0 0",
                     bus.mem_wr_enable, bus.mem_rd_enable, bus.proto_err);
            bad++;
        end
        @(negedge clk);
        total++;
        if (bus.proto_err !== 1'b1) begin
            $display("FAIL conf_pulse: perr=%b want 1", bus.proto_err);
            bad++;
        end
        bus.req_wr_en = 4'b0000;
        #1;
        total++;
        if (bus.mem_rd_enable !== 1'b1 || bus.mem_wr_enable !== 1'b0) begin
            $display("FAIL conf_read: rd=%b wr=%b, want 1 0", bus.mem_rd_enable, bus.mem_wr_enable);
            bad++;
        end
        @(negedge clk);
        total++;
        if (bus.proto_err !== 1'b0) begin
            $display("FAIL conf_pulse_end: perr=%b want 0", bus.proto_err);
            bad++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req = 4'b0010;
        bus.req_wr_en = 4'b0010;
        bus.req_addr[1*AW +: AW] = 32'h300;
        @(negedge clk);
        bus.req = 4'b0011;
        repeat (2) @(negedge clk);
        total++;
        if (bus.gnt !== 4'b0010 || bus.mem_wr_enable !== 1'b1) begin
            $display("FAIL ar_burst: gnt=%b wr=%b, want 0010 1", bus.gnt, bus.mem_wr_enable);
            bad++;
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        total++;
        if (bus.gnt !== 4'b0000 || bus.mem_wr_enable !== 1'b0 || bus.busy !== 1'b0 || bus.mem_addr !== 32'h0) begin
            $display("FAIL ar_immediate: gnt=%b wr=%b busy=%b addr=%h, want 0000 0 0 0",
                     bus.gnt, bus.mem_wr_enable, bus.busy, bus.mem_addr);
            bad++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (bus.gnt !== 4'b0001 || bus.owner_id !== 2'd0) begin
            $display("FAIL ar_restart: gnt=%b owner=%0d, want 0001 0", bus.gnt, bus.owner_id);
            bad++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_first_grant();
        test_rotation();
        test_renewal();
        test_isolation();
        test_conflict();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
